m92_cpu_sdr_responder: RTL and testbench

- Responder end of the main-CPU SDRAM port. It accepts the one-cycle request pulse carrying address, write data and byte select, and returns read data with a one-cycle ready pulse.
- Contains a direct-mapped, write-through, single-word read cache, so CPU ROM/RAM hits answer in 2 cycles without touching SDRAM.
- Misses and all writes are forwarded to a single-word backend memory handshake (SDRAM controller port).
- Sits between the V30 request logic and the SDRAM controller.

---
 rtl/m92_pkg.sv | 24 ++
 rtl/m92_cache_ram.sv | 25 ++
 rtl/m92_cpu_sdr_responder.sv | 204 ++++++++++++++++++++
 tb/tb_m92_cpu_sdr_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m92_pkg.sv
// Shared types and helpers for the M92 CPU SDRAM responder.
// Latency: none (types and combinational helpers only).
// Backpressure: not applicable.
package m92_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR
    } responder_state_t;

    // Per-byte select between the stored word and the incoming write data.
    function automatic logic [15:0] byte_merge(
        input logic [15:0] old_word,
        input logic [15:0] new_word,
        input logic [1:0]  sel
    );
        byte_merge = {sel[1] ? new_word[15:8] : old_word[15:8],
                      sel[0] ? new_word[7:0]  : old_word[7:0]};
    endfunction

endpackage

// File: rtl/m92_cache_ram.sv
// Single-port synchronous-read RAM used for cache tags and cache data.
// Latency: read data appears one clock after the address is presented.
// Backpressure: none; one access per cycle, write and read share the address.
module m92_cache_ram #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  CLK_32M,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic                  we,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Registered read; the old contents are returned on a write cycle, which the caller never consumes.
    always_ff @(posedge CLK_32M) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/m92_cpu_sdr_responder.sv
// CPU-side SDRAM responder with a direct-mapped write-through one-word-per-line read cache.
// Latency: read hit rdy two cycles after req; misses and writes wait for the backend ack.
// Backpressure: busy while a request or cache sweep is in progress; req during busy is dropped and flagged in overrun.
module m92_cpu_sdr_responder
    import m92_pkg::*;
#(
    parameter int                ADDR_W     = 25,
    parameter int                LINES_LOG2 = 8,
    parameter logic [ADDR_W-1:0] CACHE_BASE = 25'h0000000,
    parameter logic [ADDR_W-1:0] CACHE_TOP  = 25'h0100000
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       din,
    input  logic [1:0]        wr_sel,
    output logic [15:0]       dout,
    output logic              rdy,
    output logic              busy,
    output logic              overrun,
    input  logic              invalidate,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int TAG_W = ADDR_W - LINES_LOG2 - 1;

    responder_state_t        state;
    logic [LINES_LOG2-1:0]   init_cnt;
    logic                    inv_pend;
    logic [ADDR_W-1:0]       addr_q;
    logic [15:0]             din_q;
    logic [1:0]              sel_q;

    logic [LINES_LOG2-1:0]   idx_q;
    logic [TAG_W-1:0]        tag_q;
    logic                    cacheable_q;
    logic                    is_wr;
    logic                    hit;
    logic                    fill;

    logic [LINES_LOG2-1:0]   ram_idx;
    logic                    tag_we;
    logic [TAG_W:0]          tag_wdata;
    logic [TAG_W:0]          tag_rd;
    logic                    data_we;
    logic [15:0]             data_wdata;
    logic [15:0]             data_rd;

    // Modular distance from the base keeps the range test free of a constant-true compare when the base is zero.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        in_range = (a - CACHE_BASE) < (CACHE_TOP - CACHE_BASE);
    endfunction

    assign idx_q       = addr_q[LINES_LOG2:1];
    assign tag_q       = addr_q[ADDR_W-1:LINES_LOG2+1];
    assign cacheable_q = in_range(addr_q);
    assign is_wr       = |sel_q;
    assign hit         = tag_rd[TAG_W] && (tag_rd[TAG_W-1:0] == tag_q) && cacheable_q;
    assign fill        = mem_req && mem_ack && cacheable_q;

    // Shared address/write control for both RAMs: sweep in INIT, lookup on accept, merge on write hit, fill on read ack.
    always_comb begin
        ram_idx    = idx_q;
        tag_we     = 1'b0;
        tag_wdata  = {1'b1, tag_q};
        data_we    = 1'b0;
        data_wdata = mem_rdata;
        case (state)
            INIT: begin
                ram_idx   = init_cnt;
                tag_we    = 1'b1;
                tag_wdata = '0;
            end
            IDLE: begin
                ram_idx = addr[LINES_LOG2:1];
            end
            LOOKUP: begin
                data_we    = is_wr && hit;
                data_wdata = byte_merge(data_rd, din_q, sel_q);
            end
            MEM_RD: begin
                tag_we  = fill;
                data_we = fill;
            end
            default: begin
            end
        endcase
    end

    m92_cache_ram #(.WIDTH(TAG_W + 1), .DEPTH_LOG2(LINES_LOG2)) u_tag_ram (
        .CLK_32M (CLK_32M),
        .addr    (ram_idx),
        .we      (tag_we),
        .wdata   (tag_wdata),
        .rdata   (tag_rd)
    );

    m92_cache_ram #(.WIDTH(16), .DEPTH_LOG2(LINES_LOG2)) u_data_ram (
        .CLK_32M (CLK_32M),
        .addr    (ram_idx),
        .we      (data_we),
        .wdata   (data_wdata),
        .rdata   (data_rd)
    );

    // Request FSM with registered response and backend outputs; a pending flush waits for the in-flight request.
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            inv_pend  <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            sel_q     <= '0;
            dout      <= '0;
            rdy       <= 1'b0;
            busy      <= 1'b1;
            overrun   <= 1'b0;
            mem_addr  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            rdy <= 1'b0;
            if (req && busy) begin
                overrun <= 1'b1;
            end
            if (invalidate) begin
                inv_pend <= 1'b1;
            end
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (req) begin
                        addr_q <= addr;
                        din_q  <= din;
                        sel_q  <= wr_sel;
                        busy   <= 1'b1;
                        state  <= LOOKUP;
                    end else if (inv_pend) begin
                        inv_pend <= 1'b0;
                        busy     <= 1'b1;
                        state    <= INIT;
                    end
                end
                LOOKUP: begin
                    mem_addr <= {addr_q[ADDR_W-1:1], 1'b0};
                    if (is_wr) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_be    <= sel_q;
                        mem_wdata <= din_q;
                        state     <= MEM_WR;
                    end else if (hit) begin
                        dout  <= data_rd;
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        mem_be  <= 2'b11;
                        state   <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        dout    <= mem_rdata;
                        rdy     <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdy     <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m92_cpu_sdr_responder.sv
`timescale 1ns/1ps
// Self-checking bench for the CPU SDRAM responder: directed scenarios plus randomized traffic against a word-level model.
// Latency: checks read hits at exactly two cycles after req, misses/writes whenever the backend acks.
// Backpressure: drives a new req only when idle, plus deliberate reqs while busy to exercise overrun.
module tb_m92_cpu_sdr_responder;

    logic        CLK_32M = 1'b0;
    logic        reset_n;
    logic        req;
    logic [24:0] addr;
    logic [15:0] din;
    logic [1:0]  wr_sel;
    logic [15:0] dout;
    logic        rdy;
    logic        busy;
    logic        overrun;
    logic        invalidate;
    logic [24:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    m92_cpu_sdr_responder dut (
        .CLK_32M    (CLK_32M),
        .reset_n    (reset_n),
        .req        (req),
        .addr       (addr),
        .din        (din),
        .wr_sel     (wr_sel),
        .dout       (dout),
        .rdy        (rdy),
        .busy       (busy),
        .overrun    (overrun),
        .invalidate (invalidate),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #15.625 CLK_32M = ~CLK_32M;

    int checks   = 0;
    int failures = 0;
    int pcyc     = 0;
    bit mon_en   = 1'b0;

    // Expectations for the one outstanding transaction.
    bit          txn_open    = 1'b0;
    bit          mem_seen    = 1'b0;
    bit          exp_hit;
    bit          exp_wr;
    bit          exp_overrun = 1'b0;
    logic [24:0] exp_maddr;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata;
    logic [15:0] exp_dout;
    logic [15:0] last_dout   = 16'h0000;
    int          req_pc;

    // Word-level memory model, backend memory, and which word each cache line holds.
    logic [15:0] ref_mem [int];
    logic [15:0] be_mem  [int];
    bit          lv [256];
    int          lw [256];

    int be_lat = 1;
    int be_cnt = 0;
    bit be_active = 1'b0;
    int be_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dflt(input int w);
        return 16'(w) ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] s);
        logic [15:0] r;
        r = o;
        if (s[1]) r[15:8] = d[15:8];
        if (s[0]) r[7:0]  = d[7:0];
        return r;
    endfunction

    function automatic logic [15:0] ref_rd(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return dflt(w);
    endfunction

    function automatic logic [15:0] be_rd(input int w);
        if (be_mem.exists(w)) return be_mem[w];
        return dflt(w);
    endfunction

    always @(posedge CLK_32M) pcyc++;

    // Backend: acks each request after be_lat cycles of mem_req, serving its own memory.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge CLK_32M);
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            if (!reset_n) begin
                be_active = 1'b0;
            end else if (mem_req) begin
                if (!be_active) begin
                    be_active = 1'b1;
                    be_cnt    = be_lat;
                end
                if (be_cnt == 0) begin
                    be_w = int'(mem_addr[24:1]);
                    if (mem_we) be_mem[be_w] = merge(be_rd(be_w), mem_wdata, mem_be);
                    else        mem_rdata = be_rd(be_w);
                    mem_ack   = 1'b1;
                    be_active = 1'b0;
                end else begin
                    be_cnt--;
                end
            end
        end
    end

    // Compare process: backend request fields, response data, hit latency and overrun against the model.
    always @(negedge CLK_32M) begin
        if (mon_en && reset_n) begin
            if (mem_req) begin
                if (!txn_open || exp_hit) begin
                    chk("unexpected_mem_req", 32'(mem_addr), 32'hFFFFFFFF);
                end else begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
                    chk("mem_we", 32'(mem_we), 32'(exp_wr));
                    chk("mem_be", 32'(mem_be), 32'(exp_be));
                    if (exp_wr) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
                    mem_seen = 1'b1;
                end
            end
            if (rdy) begin
                if (!txn_open) begin
                    chk("spurious_rdy", 32'(rdy), 32'd0);
                end else begin
                    chk("dout", 32'(dout), 32'(exp_dout));
                    chk("overrun", 32'(overrun), 32'(exp_overrun));
                    if (exp_hit) chk("hit_latency", 32'(pcyc - req_pc), 32'd2);
                    else         chk("miss_used_backend", 32'(mem_seen), 32'd1);
                    txn_open = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK_32M);
        while ((busy || txn_open) && n < 2000) begin
            @(negedge CLK_32M);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge CLK_32M);
        end
    endtask

    task automatic txn_start(input logic [24:0] a, input logic [15:0] d, input logic [1:0] s,
                             input bit inv, input bit dbl);
        int  w;
        int  idx;
        bit  cach;
        wait_idle();
        w    = int'(a[24:1]);
        idx  = int'(a[8:1]);
        cach = (a < 25'h0100000);
        exp_wr    = (s != 2'b00);
        exp_hit   = !exp_wr && cach && lv[idx] && (lw[idx] == w);
        exp_maddr = {a[24:1], 1'b0};
        exp_be    = exp_wr ? s : 2'b11;
        exp_wdata = d;
        if (exp_wr) begin
            exp_dout   = last_dout;
            ref_mem[w] = merge(ref_rd(w), d, s);
        end else begin
            exp_dout = ref_rd(w);
            if (cach && !exp_hit) begin
                lv[idx] = 1'b1;
                lw[idx] = w;
            end
        end
        last_dout = exp_dout;
        mem_seen  = 1'b0;
        req_pc    = pcyc;
        txn_open  = 1'b1;
        req = 1'b1; addr = a; din = d; wr_sel = s;
        @(negedge CLK_32M);
        req = dbl; addr = 25'($urandom); din = 16'($urandom); wr_sel = 2'($urandom);
        invalidate = inv;
        if (dbl) exp_overrun = 1'b1;
        @(negedge CLK_32M);
        req = 1'b0; invalidate = 1'b0;
    endtask

    task automatic txn_end(input bit inv);
        int n = 0;
        while (txn_open && n < 400) begin
            @(negedge CLK_32M);
            n++;
        end
        chk("rdy_arrived", 32'(!txn_open), 32'd1);
        txn_open = 1'b0;
        if (inv) begin
            for (int i = 0; i < 256; i++) lv[i] = 1'b0;
            @(negedge CLK_32M);
        end
    endtask

    task automatic txn(input logic [24:0] a, input logic [15:0] d, input logic [1:0] s,
                       input bit inv, input bit dbl);
        txn_start(a, d, s, inv, dbl);
        txn_end(inv);
    endtask

    initial begin
        int          n;
        int          k;
        logic [24:0] ra;
        logic [15:0] rd;
        logic [1:0]  rs;

        req = 1'b0; addr = '0; din = '0; wr_sel = '0; invalidate = 1'b0; reset_n = 1'b0;
        for (int i = 0; i < 256; i++) begin lv[i] = 1'b0; lw[i] = 0; end
        repeat (3) @(negedge CLK_32M);

        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        // Release reset, measure the sweep, and poke a request into the middle of it.
        reset_n = 1'b1;
        mon_en  = 1'b1;
        n = 0;
        while (busy && n < 2000) begin
            req  = (n == 10);
            addr = 25'h0000100;
            if (n == 10) exp_overrun = 1'b1;
            n++;
            @(negedge CLK_32M);
        end
        req = 1'b0;
        chk("init_busy_cycles", 32'(n), 32'd256);
        chk("overrun_during_init", 32'(overrun), 32'd1);

        // Cold read then warm read of the same word.
        be_mem[128]  = 16'h1234;
        ref_mem[128] = 16'h1234;
        be_lat = 5;
        txn(25'h0000100, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("cold_read_dout", 32'(dout), 32'h1234);
        chk("cold_read_backend", 32'(mem_seen), 32'd1);
        be_lat = 2;
        txn(25'h0000100, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("warm_read_dout", 32'(dout), 32'h1234);
        chk("warm_read_no_backend", 32'(mem_seen), 32'd0);

        // Upper-byte write into the cached line, then read back the merged word from the cache.
        txn(25'h0000101, 16'hAB00, 2'b10, 1'b0, 1'b0);
        chk("write_backend", 32'(mem_seen), 32'd1);
        chk("write_dout_held", 32'(dout), 32'h1234);
        txn(25'h0000100, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("merged_read_dout", 32'(dout), 32'hAB34);
        chk("merged_read_no_backend", 32'(mem_seen), 32'd0);

        // Uncacheable address and the two edges of the cacheable window.
        txn(25'h0200000, 16'h0000, 2'b00, 1'b0, 1'b0);
        txn(25'h0200000, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("uncached_second_backend", 32'(mem_seen), 32'd1);
        txn(25'h00FFFFE, 16'h0000, 2'b00, 1'b0, 1'b0);
        txn(25'h00FFFFE, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("last_cacheable_hits", 32'(mem_seen), 32'd0);
        txn(25'h0100000, 16'h0000, 2'b00, 1'b0, 1'b0);
        txn(25'h0100000, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("first_uncacheable_misses", 32'(mem_seen), 32'd1);

        // Flush from idle: full sweep, then the old line misses.
        wait_idle();
        invalidate = 1'b1;
        @(negedge CLK_32M);
        invalidate = 1'b0;
        for (int i = 0; i < 256; i++) lv[i] = 1'b0;
        k = 0;
        while (!busy && k < 10) begin
            @(negedge CLK_32M);
            k++;
        end
        count_busy(n);
        chk("inval_busy_cycles", 32'(n), 32'd256);
        txn(25'h0000100, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("post_inval_backend", 32'(mem_seen), 32'd1);
        chk("post_inval_dout", 32'(dout), 32'hAB34);

        // Two words sharing one line evict each other.
        txn(25'h0000300, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("conflict_miss", 32'(mem_seen), 32'd1);
        txn(25'h0000100, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("evicted_miss", 32'(mem_seen), 32'd1);
        txn(25'h0000100, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("refilled_hit", 32'(mem_seen), 32'd0);

        // Randomized traffic over a few colliding tags, the window edge and uncacheable space.
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            if (k < 7)      ra = 25'($urandom_range(0, 2047));
            else if (k < 9) ra = 25'h0100000 + 25'($urandom_range(0, 63));
            else            ra = 25'h00FFFF0 + 25'($urandom_range(0, 15));
            rs = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
            rd = 16'($urandom);
            be_lat = $urandom_range(0, 4);
            txn(ra, rd, rs, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
        end

        // Reset while a backend read is outstanding: mem_req must drop without waiting for a clock.
        be_lat = 60;
        txn_start(25'h0100040, 16'h0000, 2'b00, 1'b0, 1'b0);
        k = 0;
        while (!mem_req && k < 50) begin
            @(negedge CLK_32M);
            k++;
        end
        chk("midreset_mem_req_up", 32'(mem_req), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_mem_req_drop", 32'(mem_req), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd1);
        chk("midreset_overrun", 32'(overrun), 32'd0);
        chk("midreset_dout", 32'(dout), 32'd0);
        txn_open    = 1'b0;
        exp_overrun = 1'b0;
        last_dout   = 16'h0000;
        for (int i = 0; i < 256; i++) lv[i] = 1'b0;
        repeat (2) @(negedge CLK_32M);
        reset_n = 1'b1;
        count_busy(n);
        chk("rereset_busy_cycles", 32'(n), 32'd256);
        be_lat = 3;
        txn(25'h0000100, 16'h0000, 2'b00, 1'b0, 1'b0);
        chk("rereset_miss", 32'(mem_seen), 32'd1);

        repeat (4) @(negedge CLK_32M);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
